// File: rtl/rv_fetch_ctrl.sv
// rv_fetch_ctrl: RV32I fetch sequencer, in-order queue, redirect/fault halt.
// Optional: define RV_FETCH_SIGILL_HALT_EN to halt after a popped illegal word.
module rv_fetch_ctrl #(
  parameter int unsigned QUEUE_DEPTH     = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        imem_resp_err,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_fault,
  input  logic        dec_sigill,
  output logic        busy
);

  localparam int unsigned AW = $clog2(QUEUE_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fault;
  } entry_t;

  entry_t        q [QUEUE_DEPTH];
  entry_t        head_e, wdata;
  state_t        state, n_state;
  logic [AW-1:0] head, tail, n_head, n_tail, widx;
  logic [CW-1:0] occ, outs, drop;
  logic [CW-1:0] n_occ, n_outs, n_drop;
  logic [CW:0]   credit;
  logic [31:0]   fetch_pc, n_fetch, resp_pc, n_rpc;
  logic          req_q, n_req, we;
  logic          fire, pop, keep, misal, sig_halt;

  assign head_e = q[head];
  assign fire   = req_q & imem_req_ready;
  assign pop    = inst_valid & inst_ready;
  assign keep   = imem_resp_valid & (drop == '0);
  assign misal  = redirect_valid & (redirect_pc[1:0] != 2'b00);
  assign n_outs = outs + CW'(fire) - CW'(imem_resp_valid);

`ifdef RV_FETCH_SIGILL_HALT_EN
  assign sig_halt = pop & dec_sigill & ~head_e.fault;
`else
  assign sig_halt = 1'b0;
  logic unused_sigill;
  assign unused_sigill = dec_sigill;
`endif

  // Next-state: queue pointers, drop credit, fetch/response PCs, issue
  always_comb begin
    n_head  = head;
    n_tail  = tail;
    n_occ   = occ;
    n_drop  = drop;
    n_state = state;
    n_fetch = fetch_pc;
    n_rpc   = resp_pc;
    we      = 1'b0;
    widx    = tail;
    wdata   = '0;
    credit  = '0;
    n_req   = 1'b0;
    if (fire) n_fetch = fetch_pc + 32'd4;
    if (imem_resp_valid && drop != '0) n_drop = drop - CW'(1);
    if (keep) n_rpc = resp_pc + 32'd4;
    if (redirect_valid) begin
      n_head  = '0;
      n_tail  = '0;
      n_occ   = '0;
      n_drop  = n_outs;
      n_fetch = redirect_pc;
      n_rpc   = redirect_pc;
      n_state = RUN;
      if (misal) begin
        we      = 1'b1;
        widx    = '0;
        wdata   = '{inst: 32'h0, pc: redirect_pc, fault: 1'b1};
        n_tail  = AW'(1);
        n_occ   = CW'(1);
        n_state = HALT;
      end
    end else if (sig_halt) begin
      n_head  = '0;
      n_tail  = '0;
      n_occ   = '0;
      n_drop  = n_outs;
      n_state = HALT;
    end else begin
      if (pop) n_head = head + AW'(1);
      if (keep) begin
        we     = 1'b1;
        n_tail = tail + AW'(1);
        if (imem_resp_err) begin
          wdata   = '{inst: 32'h0, pc: resp_pc, fault: 1'b1};
          n_drop  = n_outs;
          n_state = HALT;
        end else begin
          wdata = '{inst: imem_resp_data, pc: resp_pc, fault: 1'b0};
        end
      end
      n_occ = occ + CW'(we) - CW'(pop);
    end
    credit = {1'b0, n_occ} + {1'b0, n_outs};
    n_req  = (n_state == RUN)
           && (n_outs < CW'(MAX_OUTSTANDING))
           && (credit < (CW + 1)'(QUEUE_DEPTH));
  end

  // Control registers; request valid is registered so it holds until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      head     <= '0;
      tail     <= '0;
      occ      <= '0;
      outs     <= '0;
      drop     <= '0;
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      req_q    <= 1'b0;
    end else begin
      state    <= n_state;
      head     <= n_head;
      tail     <= n_tail;
      occ      <= n_occ;
      outs     <= n_outs;
      drop     <= n_drop;
      fetch_pc <= n_fetch;
      resp_pc  <= n_rpc;
      req_q    <= n_req;
    end
  end

  // Queue storage; contents are masked by occupancy so no reset needed
  always_ff @(posedge clk) begin
    if (we) q[widx] <= wdata;
  end

  assign imem_req_valid = req_q;
  assign imem_req_addr  = fetch_pc;
  assign inst_valid     = (occ != '0);
  assign inst           = inst_valid ? head_e.inst : 32'h0;
  assign inst_pc        = inst_valid ? head_e.pc : 32'h0;
  assign inst_fault     = inst_valid & head_e.fault;
  assign busy           = (outs != '0) | (drop != '0);

endmodule

// File: tb/tb_rv_fetch_ctrl.sv
// tb_rv_fetch_ctrl: directed bench with memory model and in-order scoreboard.
// Expected entries are queued at request acceptance, checked at each pop.
module tb_rv_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_resp_err;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;
  logic        dec_sigill;
  logic        busy;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fault;
  } ent_t;

  ent_t        exq[$];
  logic [31:0] mq[$];
  int          vectors;
  int          errs;
  int          issued;
  logic        resp_en;
  logic        halted;
  logic [31:0] err_addr;
  logic [31:0] zero_addr;
  logic [31:0] nxt;

  rv_fetch_ctrl #(
    .QUEUE_DEPTH(4),
    .MAX_OUTSTANDING(2),
    .RESET_PC(32'h0000_0100)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data),
    .imem_resp_err(imem_resp_err),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .inst(inst),
    .inst_pc(inst_pc),
    .inst_fault(inst_fault),
    .dec_sigill(dec_sigill),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a == zero_addr) ? 32'h0 : (a ^ 32'h1357_0013);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s got %h exp %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    ent_t        e;
    logic [31:0] a;
    @(negedge clk);
    dec_sigill = inst_valid && !inst_fault && (inst == 32'h0);
    if (rst_n && inst_valid && inst_ready) begin
      vectors++;
      assert (exq.size() != 0) else begin
        errs++;
        $error("FAIL pop_unexpected got pc %h exp none", inst_pc);
      end
      if (exq.size() != 0) begin
        e = exq.pop_front();
        chk("inst", inst, e.inst);
        chk("inst_pc", inst_pc, e.pc);
        chk("inst_fault", {31'b0, inst_fault}, {31'b0, e.fault});
      end
`ifdef RV_FETCH_SIGILL_HALT_EN
      if (dec_sigill) begin
        exq.delete();
        halted = 1'b1;
      end
`endif
    end
    if (rst_n && resp_en && mq.size() != 0) begin
      a = mq.pop_front();
      imem_resp_valid = 1'b1;
      imem_resp_data  = memw(a);
      imem_resp_err   = (a == err_addr);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
      imem_resp_err   = 1'b0;
    end
    if (rst_n && imem_req_valid && imem_req_ready) begin
      chk("req_addr", imem_req_addr, nxt);
      nxt = nxt + 32'd4;
      issued++;
      mq.push_back(imem_req_addr);
      if (!halted) begin
        if (imem_req_addr == err_addr) begin
          e = '{inst: 32'h0, pc: imem_req_addr, fault: 1'b1};
          halted = 1'b1;
        end else begin
          e = '{inst: memw(imem_req_addr), pc: imem_req_addr, fault: 1'b0};
        end
        exq.push_back(e);
      end
    end
    if (rst_n && redirect_valid) begin
      exq.delete();
      nxt    = redirect_pc;
      halted = (redirect_pc[1:0] != 2'b00);
      if (halted)
        exq.push_back('{inst: 32'h0, pc: redirect_pc, fault: 1'b1});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    vectors         = 0;
    errs            = 0;
    issued          = 0;
    rst_n           = 1'b0;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    imem_resp_err   = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'h0;
    inst_ready      = 1'b0;
    dec_sigill      = 1'b0;
    resp_en         = 1'b1;
    halted          = 1'b0;
    err_addr        = 32'hFFFF_FFF0;
    zero_addr       = 32'hFFFF_FFE0;
    nxt             = 32'h0000_0100;

    repeat (2) tick();
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_req_addr", imem_req_addr, 32'h100);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_inst_fault", {31'b0, inst_fault}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    rst_n = 1'b1;

    // backpressure: only QUEUE_DEPTH requests may be accepted
    repeat (12) tick();
    chk("bp_issued", 32'(issued), 32'd4);
    chk("bp_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("bp_inst_valid", {31'b0, inst_valid}, 32'd1);

    // sequential stream from 0x100
    inst_ready = 1'b1;
    repeat (20) tick();
    chk("stream_issued", {31'b0, (issued >= 16)}, 32'd1);

    // redirect with two outstanding requests
    resp_en = 1'b0;
    repeat (2) tick();
    chk("t3_busy_pre", {31'b0, busy}, 32'd1);
    imem_req_ready = 1'b0;
    redirect(32'h200);
    resp_en = 1'b1;
    repeat (4) tick();
    chk("t3_busy_post", {31'b0, busy}, 32'd0);
    chk("t3_flushed", {31'b0, inst_valid}, 32'd0);
    imem_req_ready = 1'b1;
    repeat (12) tick();

    // access fault on 0x108 halts until redirect
    err_addr = 32'h108;
    redirect(32'h100);
    repeat (15) tick();
    chk("t4_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("t4_busy", {31'b0, busy}, 32'd0);
    chk("t4_drained", 32'(exq.size()), 32'd0);
    err_addr = 32'hFFFF_FFF0;
    redirect(32'h300);
    repeat (10) tick();
    chk("t4_resumed", {31'b0, (nxt >= 32'h310)}, 32'd1);

    // misaligned redirect yields one fault entry and halts
    redirect(32'h202);
    repeat (8) tick();
    chk("t5_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("t5_drained", 32'(exq.size()), 32'd0);
    chk("t5_busy", {31'b0, busy}, 32'd0);

    // all-zero word with decoder sigill
    zero_addr = 32'h408;
    redirect(32'h400);
    repeat (12) tick();
`ifdef RV_FETCH_SIGILL_HALT_EN
    chk("t6_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("t6_drained", 32'(exq.size()), 32'd0);
`else
    chk("t6_continue", {31'b0, (nxt >= 32'h420)}, 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
